dm_store_load: RTL
==================

DM_STORE_LOAD -- requirements
Module: dm_store_load

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: WE  input  1  store request this cycle.
REQ-004 SHALL have port: DMOp  input  3  access width/extension: 000 W, 001 H signed, 010 HU, 011 B signed, 100 BU; 101-111 reserved.
REQ-005 SHALL have port: Addr  input  32  byte address.
REQ-006 SHALL have port: WD  input  32  store data, right-aligned.
REQ-007 SHALL have port: PC  input  32  PC of the accessing instruction, for the write log only.
REQ-008 SHALL have port: RD  output  32  load data, extended to 32 bits.
REQ-009 SHALL have port: Err  output  1  misaligned, out-of-range or reserved-op access.

Function
REQ-010 SHALL hold 3072 32-bit words covering byte addresses 0x0000-0x2FFF, indexed by Addr[13:2].
REQ-011 SHALL assert Err combinationally when any of these holds: DMOp W with Addr[1:0]!=0; DMOp H/HU with Addr[0]!=0; Addr>0x2FFF; DMOp reserved.
REQ-012 SHALL, on a rising clk with WE=1, Err=0 and reset=0, merge WD into the addressed word and leave all other bytes unchanged.
REQ-013 SHALL place WD[31:0] for a W store, WD[15:0] into halfword Addr[1] for an H store, and WD[7:0] into byte Addr[1:0] for a B store, little-endian (byte 0 = bits 7:0).
REQ-014 SHALL treat DMOp HU as H and BU as B on stores.
REQ-015 SHALL suppress the store entirely when Err=1, with no partial write.
REQ-016 SHALL drive RD combinationally from the current array contents, so load latency is zero cycles.
REQ-017 SHALL return the pre-edge value on RD when a store to the same word occurs in the same cycle; the new value appears after the edge.
REQ-018 SHALL select the addressed byte/halfword for RD, sign-extend it for H/B and zero-extend it for HU/BU, and return the whole word for W.
REQ-019 SHALL drive RD=0 when Err=1.
REQ-020 SHALL ignore PC functionally.

Reset
REQ-021 SHALL clear all 3072 words to 0 on a rising clk with reset=1.
REQ-022 SHALL give reset priority over a simultaneous store; that store is lost.
REQ-023 SHALL hold no other state; RD and Err follow their inputs immediately after reset.

Configuration
REQ-024 SHALL, when macro DM_DISPLAY_EN is defined, $display "%d@%h: *%h <= %h" (time, PC, word-aligned address, merged 32-bit word) once per committed store.
REQ-025 SHALL emit no log for suppressed or reset-cycle stores.
REQ-026 SHALL, without DM_DISPLAY_EN, generate no display code, with functional behaviour identical to the defined case.

Verification
REQ-027 SHALL pass: reset, then W store WD=0x12345678 @0x10, then W load @0x10 -> RD=0x12345678, Err=0.
REQ-028 SHALL pass: B store WD=0xFFFFFF80 @0x11 into word 0 -> word=0x00008000; B load @0x11 -> 0xFFFFFF80; BU load -> 0x00000080.
REQ-029 SHALL pass: H store WD=0x0000ABCD @0x22 on word 0x11112222 -> 0xABCD2222; H load @0x22 -> 0xFFFFABCD; HU load -> 0x0000ABCD.
REQ-030 SHALL pass: W store @0x6 and H store @0x3 -> Err=1, memory unchanged, RD=0; store @0x3000 -> Err=1, no write.
REQ-031 SHALL pass: W store of 0x5 @0x0 in the same cycle as reset=1 -> word 0 reads 0, no log line; a same-cycle write plus read returns the old value until the edge.

Source files
------------

// File: rtl/dm_store_load.sv
// Byte-addressable 3072-word data memory with combinational loads and merged stores.
// Optional store log enabled by defining DM_DISPLAY_EN.
module dm_store_load (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [2:0]  DMOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        Err
);

  localparam int unsigned DEPTH = 3072;
  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  logic [31:0] mem_q [DEPTH];
  logic [11:0] word_idx;
  logic [31:0] cur_word;
  logic [31:0] merged_d;
  logic [31:0] wd_lane;
  logic [3:0]  byte_en;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        is_half;
  logic        is_byte;
  logic        unused_pc;

  // PC only feeds the optional log.
  assign unused_pc = ^PC;

  assign word_idx = Addr[13:2];
  assign cur_word = mem_q[word_idx];
  assign is_half  = (DMOp == OP_H) || (DMOp == OP_HU);
  assign is_byte  = (DMOp == OP_B) || (DMOp == OP_BU);

  always_comb begin
    Err = 1'b0;
    if (Addr > 32'h0000_2FFF)                  Err = 1'b1;
    if (DMOp > OP_BU)                          Err = 1'b1;
    if ((DMOp == OP_W) && (Addr[1:0] != 2'b00)) Err = 1'b1;
    if (is_half && Addr[0])                    Err = 1'b1;
  end

  assign half_sel = Addr[1] ? cur_word[31:16] : cur_word[15:0];
  assign byte_sel = cur_word[{Addr[1:0], 3'b000} +: 8];

  always_comb begin
    RD = 32'h0;
    if (!Err) begin
      case (DMOp)
        OP_W:    RD = cur_word;
        OP_H:    RD = {{16{half_sel[15]}}, half_sel};
        OP_HU:   RD = {16'h0, half_sel};
        OP_B:    RD = {{24{byte_sel[7]}}, byte_sel};
        OP_BU:   RD = {24'h0, byte_sel};
        default: RD = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes so each byte lane only needs an enable.
  always_comb begin
    wd_lane = WD;
    byte_en = 4'b1111;
    if (is_half) begin
      wd_lane = {2{WD[15:0]}};
      byte_en = Addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_byte) begin
      wd_lane = {4{WD[7:0]}};
      byte_en = 4'b0001 << Addr[1:0];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_d[8*gi +: 8] = byte_en[gi] ? wd_lane[8*gi +: 8] : cur_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (WE && !Err) begin
      mem_q[word_idx] <= merged_d;
`ifdef DM_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged_d);
`else
`endif
    end
  end

endmodule
